// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg
//
// Shared definitions for the pseudo-random number generator:
//   - LFSR_DEFAULT_SEED : reset/reload value used when no seed is given
//   - LFSR_MIN_WIDTH / LFSR_MAX_WIDTH : supported register widths
//   - max_taps(width)   : maximal-length feedback tap mask for 3..32 bits
//                         (XAPP052 polynomials, bit i = stage i+1)
//   - lfsr_next(...)    : one Fibonacci step of a register up to 32 bits
//                         wide, including the all-zero lock-up reload
// ---------------------------------------------------------------------------
package lfsr_pkg;

    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
    localparam int          LFSR_MIN_WIDTH    = 3;
    localparam int          LFSR_MAX_WIDTH    = 32;

    // Tap masks are written with bit (n-1) standing for polynomial term x^n,
    // so the top tap of every entry is bit (width-1). Shifting left and
    // feeding back into bit 0 walks the full 2^width-1 cycle for each entry.
    // An unsupported width returns zero, which the module rejects.
    function automatic logic [31:0] max_taps(input int width);
        logic [31:0] taps;
        taps = 32'h0000_0000;
        case (width)
            3:  taps = 32'h0000_0006;
            4:  taps = 32'h0000_000C;
            5:  taps = 32'h0000_0014;
            6:  taps = 32'h0000_0030;
            7:  taps = 32'h0000_0060;
            8:  taps = 32'h0000_00B8;
            9:  taps = 32'h0000_0110;
            10: taps = 32'h0000_0240;
            11: taps = 32'h0000_0500;
            12: taps = 32'h0000_0829;
            13: taps = 32'h0000_100D;
            14: taps = 32'h0000_2015;
            15: taps = 32'h0000_6000;
            16: taps = 32'h0000_D008;
            17: taps = 32'h0001_2000;
            18: taps = 32'h0002_0400;
            19: taps = 32'h0004_0023;
            20: taps = 32'h0009_0000;
            21: taps = 32'h0014_0000;
            22: taps = 32'h0030_0000;
            23: taps = 32'h0042_0000;
            24: taps = 32'h00E1_0000;
            25: taps = 32'h0120_0000;
            26: taps = 32'h0200_0023;
            27: taps = 32'h0400_0013;
            28: taps = 32'h0900_0000;
            29: taps = 32'h1400_0000;
            30: taps = 32'h2000_0029;
            31: taps = 32'h4800_0000;
            32: taps = 32'h8020_0003;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

    // One step of a width-bit Fibonacci register held in the low bits of a
    // 32-bit word. For width 32 the shift below wraps to zero, and zero
    // minus one is the all-ones mask, so no special case is needed.
    function automatic logic [31:0] lfsr_next(
        input logic [31:0] state,
        input logic [31:0] taps,
        input logic [31:0] seed,
        input int          width
    );
        logic [31:0] mask;
        logic [31:0] cur;
        logic [31:0] nxt;
        logic        feedback;
        mask = (32'd1 << width) - 32'd1;
        cur  = state & mask;
        if (cur == 32'd0) begin
            nxt = seed & mask;
        end else begin
            feedback = ^(cur & taps & mask);
            nxt      = ((cur << 1) | {31'd0, feedback}) & mask;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr_prng.sv
// ---------------------------------------------------------------------------
// lfsr_prng
//
// Free-running maximal-length Fibonacci LFSR. Advances one step on every
// rising clock edge while rst is low; there is no enable and no handshake.
//
// Parameters:
//   WIDTH : register/output width, 3..32
//   SEED  : reset and lock-up reload value, must be nonzero
//   TAPS  : feedback mask, bit i set means state[i] feeds the XOR
//
// Ports:
//   clk : clock, register updates on the rising edge
//   rst : asynchronous active-high reset, loads SEED immediately
//   out : current register value, driven straight from the flops
// ---------------------------------------------------------------------------
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_DEFAULT_SEED),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(max_taps(WIDTH))
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out
);

    // Reject configurations that would never produce a useful sequence:
    // an out-of-range width has no tap entry, a zero seed is the lock-up
    // state itself, and without the top tap the oldest bit is ignored and
    // the register degenerates into a shorter one.
    if (WIDTH < LFSR_MIN_WIDTH || WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
        $error("lfsr_prng: WIDTH must lie in 3..32");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_prng: SEED must be nonzero");
    end
    if (TAPS[WIDTH-1] == 1'b0) begin : g_bad_taps
        $error("lfsr_prng: TAPS must include the most significant stage");
    end

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] state_next;
    logic             feedback;

    // Next-state logic: shift left with the tap parity entering at bit 0.
    // The all-zero state is a fixed point of any XOR feedback, so if it
    // ever appears (upset or forced) the register reloads SEED instead.
    always_comb begin
        feedback   = ^(state & TAPS);
        state_next = {state[WIDTH-2:0], feedback};
        if (state == '0) begin
            state_next = SEED;
        end
    end

    // State register. Reset is applied asynchronously; release must already
    // be synchronized to clk by whoever drives rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else begin
            state <= state_next;
        end
    end

    assign out = state;

endmodule

// File: tb/tb_lfsr_prng.sv
// ---------------------------------------------------------------------------
// tb_lfsr_prng
//
// Drives a default 16-bit instance and an 8-bit instance (SEED 8'h01) from a
// shared clock and reset. A predictor pushes the expected value of each
// register into queues; a monitor pops and compares them on every falling
// edge and whenever an asynchronous event is announced.
// ---------------------------------------------------------------------------
module tb_lfsr_prng;

    localparam logic [15:0] SEED16 = 16'hACE1;
    localparam logic [15:0] TAPS16 = 16'hD008;
    localparam logic [7:0]  SEED8  = 8'h01;
    localparam logic [7:0]  TAPS8  = 8'hB8;

    typedef enum {
        STIM_ASSERT_RST,
        STIM_RELEASE_RST,
        STIM_FORCE_ZERO
    } stim_e;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic        track;
    logic [15:0] out16;
    logic [7:0]  out8;

    logic [15:0] m16;
    logic [7:0]  m8;
    logic [15:0] exp16_q[$];
    logic [7:0]  exp8_q[$];
    event        sample_ev;

    int assert_count;
    int fail_count;
    int seen8[256];

    lfsr_prng dut16 (
        .clk (clk),
        .rst (rst),
        .out (out16)
    );

    lfsr_prng #(
        .WIDTH (8),
        .SEED  (8'h01)
    ) dut8 (
        .clk (clk),
        .rst (rst),
        .out (out8)
    );

    // Gated clock so the reset value can be observed with no edges running.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    // Reference step: multiply by two modulo 2^w and add the parity of the
    // tapped bits; zero is never part of the cycle and reloads the seed.
    function automatic logic [31:0] refStep(
        input logic [31:0] s,
        input logic [31:0] taps,
        input logic [31:0] seed,
        input int          w
    );
        logic [63:0] modulus;
        logic [63:0] v;
        if (s == 32'd0) return seed;
        modulus = 64'd1 << w;
        v = (64'(s) * 64'd2 + 64'($countones(s & taps) % 2)) % modulus;
        return 32'(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Predictor: on each rising edge work out what both registers must hold.
    always @(posedge clk) begin
        if (track) begin
            if (rst) begin
                m16 = SEED16;
                m8  = SEED8;
            end else begin
                m16 = 16'(refStep(32'(m16), 32'(TAPS16), 32'(SEED16), 16));
                m8  = 8'(refStep(32'(m8), 32'(TAPS8), 32'(SEED8), 8));
            end
            exp16_q.push_back(m16);
            exp8_q.push_back(m8);
        end
    end

    // Monitor: the outputs are always valid, so every falling edge (and any
    // announced asynchronous change) consumes one expectation per instance.
    initial begin
        logic [15:0] e16;
        logic [7:0]  e8;
        forever begin
            @(negedge clk or sample_ev);
            if (exp16_q.size() > 0) begin
                e16 = exp16_q.pop_front();
                checkOutput("scoreboard16", 32'(out16), 32'(e16));
            end
            if (exp8_q.size() > 0) begin
                e8 = exp8_q.pop_front();
                checkOutput("scoreboard8", 32'(out8), 32'(e8));
            end
        end
    end

    // Asynchronous actions happen a little after a falling edge so they
    // never coincide with a rising edge or with the monitor's sampling.
    task automatic applyStimulus(input stim_e op);
        @(negedge clk);
        #2;
        case (op)
            STIM_ASSERT_RST: begin
                rst = 1'b1;
                #1;
                m16 = SEED16;
                m8  = SEED8;
                exp16_q.push_back(m16);
                exp8_q.push_back(m8);
                -> sample_ev;
            end
            STIM_RELEASE_RST: begin
                rst = 1'b0;
            end
            STIM_FORCE_ZERO: begin
                force dut16.state = 16'h0000;
                force dut8.state  = 8'h00;
                #1;
                release dut16.state;
                release dut8.state;
                m16 = 16'h0000;
                m8  = 8'h00;
                exp16_q.push_back(m16);
                exp8_q.push_back(m8);
                -> sample_ev;
            end
            default: ;
        endcase
    endtask

    task automatic runCycles(input int n);
        for (int k = 0; k < n; k++) @(posedge clk);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        assert_count = 0;
        fail_count   = 0;
        clk_en       = 1'b0;
        track        = 1'b0;
        rst          = 1'b0;
        m16          = SEED16;
        m8           = SEED8;

        // Reset value with the clock stopped.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("reset_value16", 32'(out16), 32'(SEED16));
        checkOutput("reset_value8", 32'(out8), 32'(SEED8));
        exp16_q.push_back(SEED16);
        exp8_q.push_back(SEED8);
        -> sample_ev;

        track  = 1'b1;
        clk_en = 1'b1;
        runCycles(2);
        applyStimulus(STIM_RELEASE_RST);

        // Full period from reset, with the first steps and the 8-bit
        // period checked along the way.
        for (int i = 1; i <= 65535; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) checkOutput("first_step", 32'(out16), 32'h59C3);
            if (i == 2) checkOutput("second_step", 32'(out16), 32'hB386);
            checkOutput("period16_nonzero", 32'(out16 != 16'h0000), 32'd1);
            if (i < 65535) checkOutput("no_early_wrap16", 32'(out16 == SEED16), 32'd0);
            if (i == 65535) checkOutput("period16_wrap", 32'(out16), 32'(SEED16));
            if (i <= 255) seen8[out8] = seen8[out8] + 1;
            if (i == 255) begin
                checkOutput("period8_wrap", 32'(out8), 32'(SEED8));
                for (int v = 0; v < 256; v++) begin
                    checkOutput("period8_coverage", 32'(seen8[v]), (v == 0) ? 32'd0 : 32'd1);
                end
            end
        end

        // Asynchronous reset mid-run.
        runCycles(1000 + $urandom_range(0, 50));
        applyStimulus(STIM_ASSERT_RST);
        checkOutput("async_reset16", 32'(out16), 32'(SEED16));
        checkOutput("async_reset8", 32'(out8), 32'(SEED8));
        applyStimulus(STIM_RELEASE_RST);
        @(posedge clk);
        #1;
        checkOutput("restart16", 32'(out16), 32'h59C3);
        checkOutput("restart8", 32'(out8), 32'h02);

        // Lock-up recovery.
        runCycles($urandom_range(3, 30));
        applyStimulus(STIM_FORCE_ZERO);
        @(posedge clk);
        #1;
        checkOutput("lockup16", 32'(out16), 32'(SEED16));
        checkOutput("lockup8", 32'(out8), 32'(SEED8));

        // Random mix of reset pulses and forced lock-ups, checked by the
        // scoreboard alone.
        for (int s = 0; s < 8; s++) begin
            runCycles($urandom_range(5, 60));
            if ($urandom_range(0, 1) == 0) begin
                applyStimulus(STIM_ASSERT_RST);
                runCycles($urandom_range(0, 3));
                applyStimulus(STIM_RELEASE_RST);
            end else begin
                applyStimulus(STIM_FORCE_ZERO);
            end
        end
        runCycles(20);

        @(negedge clk);
        #2;
        track = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(exp16_q.size() + exp8_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
